// File: rtl/lfsr_prng.sv
// Parametrised maximal-length Fibonacci LFSR with run-time seeding, zero-seed
// rejection, multi-step advance and a wrap pulse when the sequence returns to its start value.
module lfsr_prng #(
  parameter int               WIDTH = 16,
  parameter int               STEP  = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_increment,
  input  logic             io_seed_valid,
  input  logic [WIDTH-1:0] io_seed_bits,
  output logic [WIDTH-1:0] io_out,
  output logic             io_wrap,
  output logic             io_seed_fault
);

  // Tap masks: bit t set means state_t feeds the XOR that produces state_0.
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    m = '0;
    case (w)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_B400;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]      TAPS_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be in 3..32");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("lfsr_prng: STEP must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED must be non-zero");
  end

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] adv;
  logic             wrap;
  logic             seed_fault;

  // STEP single-steps unrolled into one combinational advance
  always_comb begin
    adv = state;
    for (int k = 0; k < STEP; k++) begin
      adv = lfsr_step(adv);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SEED;
      start      <= SEED;
      wrap       <= 1'b0;
      seed_fault <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      seed_fault <= 1'b0;
      if (io_seed_valid) begin
        // An all-zero seed would lock the register, so fall back to SEED
        if (io_seed_bits != '0) begin
          state <= io_seed_bits;
          start <= io_seed_bits;
        end else begin
          state      <= SEED;
          start      <= SEED;
          seed_fault <= 1'b1;
        end
      end else if (io_increment) begin
        state <= adv;
        wrap  <= (adv == start);
      end
    end
  end

  assign io_out        = state;
  assign io_wrap       = wrap;
  assign io_seed_fault = seed_fault;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: three instances (16/1, 16/4, 4/1) driven in lock-step,
// with a reference model feeding an expected-value queue plus directed constants.
module tb_lfsr_prng;

  logic        clock;
  logic        reset;
  logic        io_increment;
  logic        seed_valid_a;
  logic [15:0] seed_bits_a;
  logic        seed_valid_b;
  logic [15:0] seed_bits_b;
  logic        seed_valid_c;
  logic [3:0]  seed_bits_c;

  logic [15:0] a_out, b_out;
  logic [3:0]  c_out;
  logic        a_wrap, b_wrap, c_wrap;
  logic        a_fault, b_fault, c_fault;

  lfsr_prng #(.WIDTH(16), .STEP(1)) dut_a (
    .clock(clock), .reset(reset), .io_increment(io_increment),
    .io_seed_valid(seed_valid_a), .io_seed_bits(seed_bits_a),
    .io_out(a_out), .io_wrap(a_wrap), .io_seed_fault(a_fault));

  lfsr_prng #(.WIDTH(16), .STEP(4)) dut_b (
    .clock(clock), .reset(reset), .io_increment(io_increment),
    .io_seed_valid(seed_valid_b), .io_seed_bits(seed_bits_b),
    .io_out(b_out), .io_wrap(b_wrap), .io_seed_fault(b_fault));

  lfsr_prng #(.WIDTH(4), .STEP(1)) dut_c (
    .clock(clock), .reset(reset), .io_increment(io_increment),
    .io_seed_valid(seed_valid_c), .io_seed_bits(seed_bits_c),
    .io_out(c_out), .io_wrap(c_wrap), .io_seed_fault(c_fault));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          dut;
    logic [15:0] out;
    logic        wrap;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  // Reference model state: current value and start value per instance
  logic [15:0] ma, msa, mb, msb;
  logic [3:0]  mc, msc;

  function automatic logic [15:0] m16(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [3:0] m4(input logic [3:0] s);
    logic fb;
    fb = s[3] ^ s[2];
    return {s[2:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle(input logic rst, input logic inc, input logic sv, input logic [15:0] sb);
    exp_t e;
    logic wa, fa, wb, wc;
    reset        = rst;
    io_increment = inc;
    seed_valid_a = sv;
    seed_bits_a  = sb;
    wa = 1'b0; fa = 1'b0; wb = 1'b0; wc = 1'b0;
    if (rst) begin
      ma = 16'h0001; msa = 16'h0001;
      mb = 16'h0001; msb = 16'h0001;
      mc = 4'h1;     msc = 4'h1;
    end else begin
      if (sv) begin
        if (sb != 16'h0) begin ma = sb; msa = sb; end
        else begin ma = 16'h0001; msa = 16'h0001; fa = 1'b1; end
      end else if (inc) begin
        ma = m16(ma);
        wa = (ma == msa);
      end
      if (inc) begin
        for (int k = 0; k < 4; k++) mb = m16(mb);
        wb = (mb == msb);
        mc = m4(mc);
        wc = (mc == msc);
      end
    end
    e.dut = 0; e.out = ma;           e.wrap = wa; e.fault = fa; sb_q.push_back(e);
    e.dut = 1; e.out = mb;           e.wrap = wb; e.fault = 0;  sb_q.push_back(e);
    e.dut = 2; e.out = {12'h0, mc};  e.wrap = wc; e.fault = 0;  sb_q.push_back(e);
    @(posedge clock);
    #1;
    cyc++;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.dut)
        0: begin
          chk($sformatf("A.out@%0d", cyc), {16'h0, a_out}, {16'h0, e.out});
          chk($sformatf("A.wrap@%0d", cyc), {31'h0, a_wrap}, {31'h0, e.wrap});
          chk($sformatf("A.fault@%0d", cyc), {31'h0, a_fault}, {31'h0, e.fault});
        end
        1: begin
          chk($sformatf("B.out@%0d", cyc), {16'h0, b_out}, {16'h0, e.out});
          chk($sformatf("B.wrap@%0d", cyc), {31'h0, b_wrap}, {31'h0, e.wrap});
          chk($sformatf("B.fault@%0d", cyc), {31'h0, b_fault}, {31'h0, e.fault});
        end
        default: begin
          chk($sformatf("C.out@%0d", cyc), {28'h0, c_out}, {16'h0, e.out});
          chk($sformatf("C.wrap@%0d", cyc), {31'h0, c_wrap}, {31'h0, e.wrap});
          chk($sformatf("C.fault@%0d", cyc), {31'h0, c_fault}, {31'h0, e.fault});
        end
      endcase
    end
  endtask

  logic [15:0] rec [1:15];
  logic [15:0] a_at12, b_at3;
  logic [15:0] seen;
  int          distinct, c_wraps, c_wrap_pos, a_wraps;

  initial begin
    reset = 1'b1; io_increment = 1'b0;
    seed_valid_a = 1'b0; seed_bits_a = '0;
    seed_valid_b = 1'b0; seed_bits_b = '0;
    seed_valid_c = 1'b0; seed_bits_c = '0;
    ma = '0; msa = '0; mb = '0; msb = '0; mc = '0; msc = '0;
    a_at12 = '0; b_at3 = '0; seen = '0;
    distinct = 0; c_wraps = 0; c_wrap_pos = 0; a_wraps = 0;

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("reset.out", {16'h0, a_out}, 32'h0001);
    chk("reset.wrap", {31'h0, a_wrap}, 32'h0);
    chk("reset.fault", {31'h0, a_fault}, 32'h0);

    // Continuous increments from reset
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (i <= 15) rec[i] = a_out;
      if (a_wrap) a_wraps++;
      if (i <= 15 && !seen[c_out]) begin seen[c_out] = 1'b1; distinct++; end
      if (c_wrap) begin c_wraps++; if (c_wraps == 1) c_wrap_pos = i; end
      if (i == 3) begin
        b_at3 = b_out;
        chk("B.step4x3", {16'h0, b_out}, 32'h1002);
      end
      if (i == 10) chk("A.inc10", {16'h0, a_out}, 32'h0400);
      if (i == 11) chk("A.inc11", {16'h0, a_out}, 32'h0801);
      if (i == 12) a_at12 = a_out;
      if (i == 15) begin
        chk("C.distinct", distinct, 15);
        chk("C.wraps15", c_wraps, 1);
        chk("C.wrap_pos", c_wrap_pos, 15);
        chk("C.out15", {28'h0, c_out}, 32'h1);
      end
    end
    chk("B3.vs.A12", {16'h0, b_at3}, {16'h0, a_at12});
    chk("C.wraps30", c_wraps, 2);
    chk("C.wrap30", {31'h0, c_wrap}, 32'h1);
    chk("A.no_wrap", a_wraps, 0);

    // Reset mid-run after 7 increments, sequence restarts identically
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 7; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("midreset.out", {16'h0, a_out}, 32'h0001);
    chk("midreset.wrap", {31'h0, a_wrap}, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      chk($sformatf("restart.%0d", i), {16'h0, a_out}, {16'h0, rec[i]});
    end

    // Zero seed rejected, with a concurrent increment dropped
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    chk("zseed.out", {16'h0, a_out}, 32'h0001);
    chk("zseed.fault", {31'h0, a_fault}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    chk("zseed.fault_clr", {31'h0, a_fault}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      chk($sformatf("zseed.seq%0d", i), {16'h0, a_out}, {16'h0, rec[i]});
    end

    // Seed 0xACE1 with increment: increment dropped, full-period wrap
    cycle(1'b0, 1'b1, 1'b1, 16'hACE1);
    chk("seed.out", {16'h0, a_out}, 32'hACE1);
    chk("seed.wrap", {31'h0, a_wrap}, 32'h0);
    a_wraps = 0;
    for (int i = 1; i <= 65535; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0);
      if (a_wrap) a_wraps++;
    end
    chk("full.wraps", a_wraps, 1);
    chk("full.out", {16'h0, a_out}, 32'hACE1);
    chk("full.wrap", {31'h0, a_wrap}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
